video_timing: RTL and testbench

Free-running raster generator that produces the `video_x`/`video_y` beam coordinates, sync, blanking and line/frame strobes consumed by the colour-bar and screen-composition stages. It sits directly upstream of the pixel-colour logic. Everything runs in the single `clock` domain, and every output is registered. The default geometry is a 448×312 raster with a 352×288 visible area, which contains the 256×192 screen window at offset (48,48).

---
 rtl/video_timing_if.sv | 47 ++++
 rtl/video_timing.sv | 121 ++++++++++++
 tb/tb_video_timing.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/video_timing_if.sv
// Raster bus between the video timing generator and its downstream consumers
// (colour-bar and screen-composition stages). The generator owns every signal
// except pixel_en, which the consumer side supplies as the pixel-rate enable.
// Optional signal: frame_count exists only when VIDEO_TIMING_FRAME_COUNT_EN is defined.
interface video_timing_if;
    logic       pixel_en;
    logic [8:0] video_x;
    logic [8:0] video_y;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       line_start;
    logic       frame_start;
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic [7:0] frame_count;
`endif

    // Generator side: consumes the enable, produces the raster.
    modport master (
        input  pixel_en,
        output video_x,
        output video_y,
        output hsync,
        output vsync,
        output blank,
        output line_start,
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        output frame_count,
`endif
        output frame_start
    );

    // Consumer side: supplies the enable, observes the raster.
    modport slave (
        output pixel_en,
        input  video_x,
        input  video_y,
        input  hsync,
        input  vsync,
        input  blank,
        input  line_start,
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        input  frame_count,
`endif
        input  frame_start
    );
endinterface

// File: rtl/video_timing.sv
// Free-running raster generator: x/y beam counters with sync, blanking and
// line/frame strobes, all registered together so the decode always describes
// the coordinates currently on video_x/video_y.
// Optional feature: define VIDEO_TIMING_FRAME_COUNT_EN to add an 8-bit
// frame counter on the frame_count signal of the interface.
module video_timing #(
    parameter int H_TOTAL     = 448,
    parameter int V_TOTAL     = 312,
    parameter int H_ACTIVE    = 352,
    parameter int V_ACTIVE    = 288,
    parameter int HSYNC_START = 384,
    parameter int HSYNC_WIDTH = 32,
    parameter int VSYNC_START = 296,
    parameter int VSYNC_WIDTH = 4
) (
    input logic            clock,
    input logic            reset_n,
    video_timing_if.master vif
);

    // Last coordinate on each axis; totals up to 512 still fit in 9 bits.
    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

    // Window bounds are kept at 10 bits so START + WIDTH = 512 cannot wrap.
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(HSYNC_START);
    localparam logic [9:0] HS_END   = 10'(HSYNC_START) + 10'(HSYNC_WIDTH);
    localparam logic [9:0] VS_BEGIN = 10'(VSYNC_START);
    localparam logic [9:0] VS_END   = 10'(VSYNC_START) + 10'(VSYNC_WIDTH);

    // Unsigned half-open window test: lo <= v < hi.
    function automatic logic in_window(input logic [8:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return ({1'b0, v} >= lo) && ({1'b0, v} < hi);
    endfunction

    logic [8:0] x_q;
    logic [8:0] y_q;
    logic       hsync_q;
    logic       vsync_q;
    logic       blank_q;
    logic       line_start_q;
    logic       frame_start_q;

    logic       x_wrap;
    logic       y_wrap;
    logic [8:0] x_next;
    logic [8:0] y_next;

    // Next raster position if this cycle advances.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can leave it unassigned and infer a latch.
        x_wrap = 1'b0;
        y_wrap = 1'b0;
        x_next = x_q;
        y_next = y_q;

        x_wrap = (x_q == H_LAST);
        y_wrap = (y_q == V_LAST);

        if (x_wrap) begin
            x_next = '0;
            y_next = y_wrap ? '0 : 9'(y_q + 9'd1);
        end else begin
            x_next = 9'(x_q + 9'd1);
        end
    end

    // Counters and decode advance together; strobes last one clock only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (vif.pixel_en) begin
            x_q           <= x_next;
            y_q           <= y_next;
            hsync_q       <= in_window(x_next, HS_BEGIN, HS_END);
            vsync_q       <= in_window(y_next, VS_BEGIN, VS_END);
            blank_q       <= ({1'b0, x_next} >= H_ACT) || ({1'b0, y_next} >= V_ACT);
            line_start_q  <= x_wrap;
            frame_start_q <= x_wrap && y_wrap;
        end else begin
            // A stalled cycle holds the raster but never stretches a strobe.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

`ifdef VIDEO_TIMING_FRAME_COUNT_EN
    logic [7:0] frame_count_q;

    // Counts frame wraps; updates on the same edge that raises frame_start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame_count_q <= '0;
        end else if (vif.pixel_en && x_wrap && y_wrap) begin
            frame_count_q <= 8'(frame_count_q + 8'd1);
        end
    end

    assign vif.frame_count = frame_count_q;
`endif

    assign vif.video_x     = x_q;
    assign vif.video_y     = y_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.blank       = blank_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing on a reduced 24x10 raster so whole
// frames fit in a short run. A position model (count of advancing edges,
// folded into x/y by division) predicts every output each cycle; directed
// literal checks pin the model at the interesting boundaries.
module tb_video_timing;

    localparam int HT     = 24;
    localparam int VT     = 10;
    localparam int HA     = 16;
    localparam int VA     = 7;
    localparam int HS     = 18;
    localparam int HW     = 3;
    localparam int VS     = 8;
    localparam int VW     = 1;
    localparam int PERIOD = HT * VT;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    video_timing_if vif ();

    video_timing #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .HSYNC_START (HS),
        .HSYNC_WIDTH (HW),
        .VSYNC_START (VS),
        .VSYNC_WIDTH (VW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .vif     (vif)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: number of advancing edges since reset, plus strobe expectations.
    int   adv;
    logic m_ls;
    logic m_fs;
    int   m_frames;

    // Model state follows the advancing edges seen by the DUT.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            adv      <= 0;
            m_ls     <= 1'b0;
            m_fs     <= 1'b0;
            m_frames <= 0;
        end else if (vif.pixel_en) begin
            adv      <= adv + 1;
            m_ls     <= (((adv + 1) % PERIOD) % HT) == 0;
            m_fs     <= ((adv + 1) % PERIOD) == 0;
            m_frames <= m_frames + ((((adv + 1) % PERIOD) == 0) ? 1 : 0);
        end else begin
            m_ls <= 1'b0;
            m_fs <= 1'b0;
        end
    end

    int c_pos;
    int c_x;
    int c_y;

    // Every-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clock) begin
        c_pos = adv % PERIOD;
        c_x   = c_pos % HT;
        c_y   = c_pos / HT;
        check("model_x",     int'(vif.video_x), c_x);
        check("model_y",     int'(vif.video_y), c_y);
        check("model_hsync", int'(vif.hsync), (c_x >= HS && c_x < HS + HW) ? 1 : 0);
        check("model_vsync", int'(vif.vsync), (c_y >= VS && c_y < VS + VW) ? 1 : 0);
        check("model_blank", int'(vif.blank), (c_x >= HA || c_y >= VA) ? 1 : 0);
        check("model_line_start",  int'(vif.line_start),  int'(m_ls));
        check("model_frame_start", int'(vif.frame_start), int'(m_fs));
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        check("model_frame_count", int'(vif.frame_count), m_frames % 256);
`endif
    end

    // Advance n edges with the enable held high, then settle past the edge.
    task automatic advance(input int n);
        vif.pixel_en = 1'b1;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_xy(input string name, input int ex, input int ey);
        check({name, "_x"}, int'(vif.video_x), ex);
        check({name, "_y"}, int'(vif.video_y), ey);
    endtask

    int ls_times[$];

    initial begin
        vif.pixel_en = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state.
        expect_xy("reset", 0, 0);
        check("reset_hsync", int'(vif.hsync), 0);
        check("reset_vsync", int'(vif.vsync), 0);
        check("reset_blank", int'(vif.blank), 0);
        check("reset_line_start", int'(vif.line_start), 0);
        check("reset_frame_start", int'(vif.frame_start), 0);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        check("reset_frame_count", int'(vif.frame_count), 0);
`endif
        #2 reset_n = 1'b1;

        // Horizontal sweep, blank and hsync boundaries.
        advance(15); expect_xy("x15", 15, 0); check("blank_x15", int'(vif.blank), 0);
        advance(1);  check("blank_x16", int'(vif.blank), 1);
        advance(1);  check("hsync_x17", int'(vif.hsync), 0);
        advance(1);  check("hsync_x18", int'(vif.hsync), 1);
        advance(2);  check("hsync_x20", int'(vif.hsync), 1);
        advance(1);  check("hsync_x21", int'(vif.hsync), 0);
        advance(2);  expect_xy("x23", 23, 0); check("ls_x23", int'(vif.line_start), 0);
        advance(1);  expect_xy("wrap1", 0, 1); check("ls_wrap1", int'(vif.line_start), 1);
        check("fs_wrap1", int'(vif.frame_start), 0);
        advance(1);  check("ls_after", int'(vif.line_start), 0);

        // Vertical sync window (adv 191 -> 192 -> 216).
        advance(166); expect_xy("y7_end", 23, 7); check("vsync_y7", int'(vif.vsync), 0);
        advance(1);   expect_xy("y8", 0, 8); check("vsync_y8", int'(vif.vsync), 1);
        check("blank_y8", int'(vif.blank), 1);
        advance(24);  expect_xy("y9", 0, 9); check("vsync_y9", int'(vif.vsync), 0);

        // Frame wrap at adv 240 and again one period later.
        advance(23);  check("fs_pre", int'(vif.frame_start), 0);
        advance(1);   expect_xy("frame1", 0, 0);
        check("fs_frame1", int'(vif.frame_start), 1);
        check("ls_frame1", int'(vif.line_start), 1);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        check("fc_frame1", int'(vif.frame_count), 1);
`endif
        advance(PERIOD - 1); check("fs_frame2_pre", int'(vif.frame_start), 0);
        advance(1);          check("fs_frame2", int'(vif.frame_start), 1);
`ifdef VIDEO_TIMING_FRAME_COUNT_EN
        check("fc_frame2", int'(vif.frame_count), 2);
`endif

        // Enable gating with pattern 1,0,0,1: line period doubles to 2*HT.
        for (int i = 0; i < 160; i++) begin
            vif.pixel_en = ((i % 4) == 0) || ((i % 4) == 3);
            @(posedge clock);
            #1;
            if (vif.line_start) ls_times.push_back(i);
        end
        check("gated_ls_count", ls_times.size(), 3);
        if (ls_times.size() >= 3) begin
            check("gated_period_a", ls_times[1] - ls_times[0], 2 * HT);
            check("gated_period_b", ls_times[2] - ls_times[1], 2 * HT);
        end
        expect_xy("gated_end", 8, 3);

        // Asynchronous reset mid-frame at (10,5).
        advance(50); expect_xy("pre_reset", 10, 5);
        #2 reset_n = 1'b0;
        #1;
        expect_xy("async_reset", 0, 0);
        check("async_blank", int'(vif.blank), 0);
        check("async_line_start", int'(vif.line_start), 0);
        repeat (2) @(posedge clock);
        #3 reset_n = 1'b1;
        advance(23); expect_xy("rel_x23", 23, 0); check("rel_ls_x23", int'(vif.line_start), 0);
        advance(1);  expect_xy("rel_wrap", 0, 1);
        check("rel_ls_wrap", int'(vif.line_start), 1);
        check("rel_fs_wrap", int'(vif.frame_start), 0);

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
